// File: rtl/if_id_buffer_if.sv
// Fetch/hazard -> IF/ID buffer -> Decode signal bundle.
// The master side is the surrounding pipeline; the slave side is the buffer.
interface if_id_buffer_if #(
   parameter int WIDTH = 16
);
   logic             fetch_valid;
   logic [WIDTH-1:0] instruction;
   logic [WIDTH-1:0] pc_in;
   logic             stall;
   logic             flush;
   logic [WIDTH-1:0] inst_out;
   logic [WIDTH-1:0] imm_out;
   logic [WIDTH-1:0] pc_out;
   logic             valid_out;
   logic             imm_valid;
   logic             waiting_imm;

   modport master (
      output fetch_valid, instruction, pc_in, stall, flush,
      input  inst_out, imm_out, pc_out, valid_out, imm_valid, waiting_imm
   );

   modport slave (
      input  fetch_valid, instruction, pc_in, stall, flush,
      output inst_out, imm_out, pc_out, valid_out, imm_valid, waiting_imm
   );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register. Passes single-word instructions straight through
// with one edge of latency and assembles two-word (opcode + immediate)
// instructions, emitting bubbles while the immediate word is outstanding.
module if_id_buffer #(
   parameter int               WIDTH      = 16,
   parameter logic [1:0]       IMM_PREFIX = 2'b11,
   parameter logic [WIDTH-1:0] NOP_WORD   = '0
) (
   input  logic          clk,
   input  logic          reset,
   if_id_buffer_if.slave bus
);

   typedef enum logic {NORMAL, WAIT_IMM} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] held_inst_q, held_inst_d;
   logic [WIDTH-1:0] held_pc_q, held_pc_d;
   logic [WIDTH-1:0] inst_q, inst_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             valid_q, valid_d;
   logic             imm_valid_q, imm_valid_d;
   logic             is_prefix;

   assign is_prefix = (bus.instruction[WIDTH-1 -: 2] == IMM_PREFIX);

   // Next-state: flush beats stall beats normal flow. Bubbles leave pc_out
   // alone so it only moves together with a valid instruction.
   always_comb begin
      state_d     = state_q;
      held_inst_d = held_inst_q;
      held_pc_d   = held_pc_q;
      inst_d      = inst_q;
      imm_d       = imm_q;
      pc_d        = pc_q;
      valid_d     = valid_q;
      imm_valid_d = imm_valid_q;
      if (bus.flush) begin
         state_d     = NORMAL;
         held_inst_d = '0;
         held_pc_d   = '0;
         inst_d      = NOP_WORD;
         imm_d       = '0;
         valid_d     = 1'b0;
         imm_valid_d = 1'b0;
      end else if (!bus.stall) begin
         // default this edge is a bubble; overridden below when a full
         // instruction becomes available
         inst_d      = NOP_WORD;
         imm_d       = '0;
         valid_d     = 1'b0;
         imm_valid_d = 1'b0;
         if (bus.fetch_valid) begin
            if (state_q == WAIT_IMM) begin
               // any encoding is accepted as the immediate word
               inst_d      = held_inst_q;
               pc_d        = held_pc_q;
               imm_d       = bus.instruction;
               valid_d     = 1'b1;
               imm_valid_d = 1'b1;
               state_d     = NORMAL;
            end else if (is_prefix) begin
               held_inst_d = bus.instruction;
               held_pc_d   = bus.pc_in;
               state_d     = WAIT_IMM;
            end else begin
               inst_d  = bus.instruction;
               pc_d    = bus.pc_in;
               valid_d = 1'b1;
            end
         end
      end
   end

   // State and output registers; reset drops any half-assembled instruction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= NORMAL;
         held_inst_q <= '0;
         held_pc_q   <= '0;
         inst_q      <= NOP_WORD;
         imm_q       <= '0;
         pc_q        <= '0;
         valid_q     <= 1'b0;
         imm_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         held_inst_q <= held_inst_d;
         held_pc_q   <= held_pc_d;
         inst_q      <= inst_d;
         imm_q       <= imm_d;
         pc_q        <= pc_d;
         valid_q     <= valid_d;
         imm_valid_q <= imm_valid_d;
      end
   end

   assign bus.inst_out    = inst_q;
   assign bus.imm_out     = imm_q;
   assign bus.pc_out      = pc_q;
   assign bus.valid_out   = valid_q;
   assign bus.imm_valid   = imm_valid_q;
   assign bus.waiting_imm = (state_q == WAIT_IMM);

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the buffer.
module tb_if_id_buffer;

   localparam int W = 16;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   if_id_buffer_if #(.WIDTH(W)) bus ();

   if_id_buffer #(.WIDTH(W), .IMM_PREFIX(2'b11), .NOP_WORD(16'h0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: is an opcode pending, what it is, and what Decode should see
   bit          m_pend;
   logic [15:0] m_op, m_oppc;
   logic [15:0] e_inst, e_imm, e_pc;
   bit          e_v, e_iv;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".inst"}, 32'(bus.inst_out), 32'(e_inst));
      chk({tag, ".imm"},  32'(bus.imm_out),  32'(e_imm));
      chk({tag, ".pc"},   32'(bus.pc_out),   32'(e_pc));
      chk({tag, ".v"},    32'(bus.valid_out), 32'(e_v));
      chk({tag, ".iv"},   32'(bus.imm_valid), 32'(e_iv));
      chk({tag, ".wait"}, 32'(bus.waiting_imm), 32'(m_pend));
   endtask

   function automatic void model_reset();
      m_pend = 0; m_op = 0; m_oppc = 0;
      e_inst = 0; e_imm = 0; e_pc = 0; e_v = 0; e_iv = 0;
   endfunction

   // what Decode should receive after one edge with these inputs
   function automatic void model_edge(bit fv, logic [15:0] w, logic [15:0] pc, bit st, bit fl);
      if (fl) begin
         m_pend = 0;
         e_inst = 0; e_imm = 0; e_v = 0; e_iv = 0;
      end else if (!st) begin
         e_inst = 0; e_imm = 0; e_v = 0; e_iv = 0;
         if (fv && m_pend) begin
            e_inst = m_op; e_pc = m_oppc; e_imm = w; e_v = 1; e_iv = 1;
            m_pend = 0;
         end else if (fv && w[15:14] == 2'b11) begin
            m_pend = 1; m_op = w; m_oppc = pc;
         end else if (fv) begin
            e_inst = w; e_pc = pc; e_v = 1;
         end
      end
   endfunction

   // one edge; called and returns at posedge+1
   task automatic cyc(input bit fv, input logic [15:0] w, input logic [15:0] pc,
                      input bit st, input bit fl, input string tag);
      bus.fetch_valid = fv; bus.instruction = w; bus.pc_in = pc;
      bus.stall = st; bus.flush = fl;
      @(posedge clk);
      model_edge(fv, w, pc, st, fl);
      #1;
      chk_all(tag);
   endtask

   // async reset in the middle of a cycle; outputs must clear before any edge
   task automatic mid_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk_all(tag);
      #1 reset = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      reset = 1'b1;
      bus.fetch_valid = 0; bus.instruction = 0; bus.pc_in = 0;
      bus.stall = 0; bus.flush = 0;
      model_reset();
      #3 chk_all("reset");
      @(posedge clk); #1 reset = 1'b0;

      // single-word pass-through
      cyc(1, 16'h1234, 16'd0, 0, 0, "sw0");
      cyc(1, 16'h2001, 16'd1, 0, 0, "sw1");
      // two-word assembly
      cyc(1, 16'hC005, 16'd4, 0, 0, "tw_op");
      cyc(1, 16'h00FF, 16'd5, 0, 0, "tw_imm");
      // stall holds for three edges, then the presented word lands
      cyc(1, 16'h1111, 16'd6, 0, 0, "st_acc");
      cyc(1, 16'h2222, 16'd7, 1, 0, "st1");
      cyc(1, 16'h3333, 16'd7, 1, 0, "st2");
      cyc(1, 16'h4444, 16'd7, 1, 0, "st3");
      cyc(1, 16'h4444, 16'd7, 0, 0, "st_rel");
      // flush while waiting for an immediate
      cyc(1, 16'hC0AA, 16'd8, 0, 0, "fl_op");
      cyc(1, 16'h0042, 16'd9, 0, 1, "fl");
      cyc(1, 16'h3003, 16'd20, 0, 0, "fl_next");
      // flush together with stall: flush wins
      cyc(1, 16'hC0AA, 16'd21, 0, 0, "fs_op");
      cyc(1, 16'h0001, 16'd22, 1, 1, "fs");
      // bubbles while waiting, prefix-class word taken as immediate
      cyc(1, 16'hC0AA, 16'd30, 0, 0, "wt_op");
      cyc(0, 16'hDEAD, 16'd31, 0, 0, "wt_b1");
      cyc(0, 16'hBEEF, 16'd31, 0, 0, "wt_b2");
      cyc(1, 16'hFFFF, 16'd31, 0, 0, "wt_imm");
      // async reset with a valid two-word instruction on the outputs
      mid_reset("ar_valid");
      // async reset while in WAIT_IMM
      cyc(1, 16'hC123, 16'd40, 0, 0, "ar_op");
      mid_reset("ar_wait");
      cyc(1, 16'h0777, 16'd41, 0, 0, "ar_post");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         if ($urandom_range(0, 2) == 0) w[15:14] = 2'b11;
         cyc(bit'($urandom_range(0, 3) != 0), w, 16'($urandom),
             bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 11) == 0), "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
